// File: rtl/fp_pkg.sv
// Shared binary32 types and constants for the FP adder datapath.
// Imported by the rounding/packing stage and its helpers.
package fp_pkg;

  localparam int EXP_N      = 8;
  localparam int MANTISSA_N = 25;
  localparam int OUT_N      = 32;
  localparam int BIAS       = 127;

  localparam logic [EXP_N-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

  localparam float32_t POS_INF = float32_t'(32'h7F80_0000);
  localparam float32_t NEG_INF = float32_t'(32'hFF80_0000);

endpackage

// File: rtl/round_decide.sv
// Rounding increment decision; round-to-nearest, ties to even.
// Kept separate so other rounding modes can slot in later.
module round_decide
  import fp_pkg::*;
(
  input  logic lsb_i,
  input  grs_t grs_i,
  output logic round_up_o
);

  assign round_up_o = grs_i.guard &
                      (grs_i.round | grs_i.sticky | lsb_i);

endmodule

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and binary32 packing after normalization.
// Two registered stages with valid/ready on both sides.
module fp_round_pack #(
  parameter int MANTISSA_N = fp_pkg::MANTISSA_N,
  parameter int EXP_N      = fp_pkg::EXP_N,
  parameter int OUT_N      = fp_pkg::OUT_N
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  sign,
  input  logic [MANTISSA_N-1:0] normedMantissa,
  input  logic [EXP_N-1:0]      normedExp,
  input  logic                  mantValid,
  input  logic [2:0]            grs,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [OUT_N-1:0]      result,
  output logic                  overflow,
  output logic                  underflow
);

  import fp_pkg::*;

  if (OUT_N != 1 + EXP_N + MANTISSA_N - 2) begin : g_bad_width
    $error("OUT_N must equal 1 + EXP_N + MANTISSA_N - 2");
  end

  localparam int FRAC_N = MANTISSA_N - 2;

  logic s2_adv;
  logic s1_adv;

  logic                  s1_valid_q;
  logic                  s1_sign_q;
  logic                  s1_mv_q;
  logic [EXP_N-1:0]      s1_exp_q;
  logic [MANTISSA_N-1:0] s1_sum_q;

  logic                  s2_valid_q;
  logic [OUT_N-1:0]      result_q;
  logic                  ovf_q;
  logic                  unf_q;

  logic                  round_up;
  logic [MANTISSA_N-1:0] sum_d;
  logic                  unused_msb;

  // Stall propagates back combinationally so a full pipe still streams.
  assign s2_adv   = !s2_valid_q | outReady;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign inReady  = s1_adv;
  assign outValid = s2_valid_q;

  assign unused_msb = normedMantissa[MANTISSA_N-1];

  round_decide u_round (
    .lsb_i      (normedMantissa[0]),
    .grs_i      (grs_t'(grs)),
    .round_up_o (round_up)
  );

  assign sum_d = {1'b0, normedMantissa[MANTISSA_N-2:0]} +
                 {{(MANTISSA_N-1){1'b0}}, round_up};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mv_q    <= 1'b0;
      s1_exp_q   <= '0;
      s1_sum_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= inValid;
      s1_sign_q  <= sign;
      s1_mv_q    <= mantValid;
      s1_exp_q   <= normedExp;
      s1_sum_q   <= sum_d;
    end
  end

  logic             carry;
  logic [EXP_N:0]   exp_out;
  logic [FRAC_N-1:0] frac_out;
  float32_t         pack_d;
  logic             ovf_d;
  logic             unf_d;

  assign carry    = s1_sum_q[MANTISSA_N-1];
  assign exp_out  = {1'b0, s1_exp_q} + {{EXP_N{1'b0}}, carry};
  assign frac_out = carry ? s1_sum_q[MANTISSA_N-2:1]
                          : s1_sum_q[FRAC_N-1:0];

  // Zero and flush win over rounding; saturation only for live values.
  always_comb begin
    pack_d      = '0;
    pack_d.sign = s1_sign_q;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    priority case (1'b1)
      !s1_mv_q: begin
      end
      (s1_exp_q == '0): begin
        unf_d = 1'b1;
      end
      (exp_out >= {1'b0, EXP_MAX}): begin
        pack_d.exp = EXP_MAX;
        ovf_d      = 1'b1;
      end
      default: begin
        pack_d.exp  = exp_out[EXP_N-1:0];
        pack_d.frac = frac_out;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      result_q   <= pack_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed vectors, random stream vs model,
// back-pressure and asynchronous reset scenarios.
module tb_fp_round_pack;

  logic        clock = 1'b0;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic        sign;
  logic [24:0] normedMantissa;
  logic [7:0]  normedExp;
  logic        mantValid;
  logic [2:0]  grs;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fp_round_pack dut (
    .clock          (clock),
    .resetN         (resetN),
    .inValid        (inValid),
    .inReady        (inReady),
    .sign           (sign),
    .normedMantissa (normedMantissa),
    .normedExp      (normedExp),
    .mantValid      (mantValid),
    .grs            (grs),
    .outValid       (outValid),
    .outReady       (outReady),
    .result         (result),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  // Value-level model: {overflow, underflow, result}.
  function automatic logic [33:0] ref_model(
    input logic s, input logic [24:0] m, input logic [7:0] e,
    input logic mv, input logic [2:0] g);
    longint q;
    int     ex;
    int     tail;
    q    = m[23:0];
    ex   = e;
    tail = g;
    if (!mv) return {2'b00, s, 31'b0};
    if (ex == 0) return {2'b01, s, 31'b0};
    if (tail > 4 || (tail == 4 && q % 2 == 1)) q = q + 1;
    if (q >= 64'd16777216) begin
      q  = q / 2;
      ex = ex + 1;
    end
    if (ex >= 255) return {2'b10, s, 8'hFF, 23'b0};
    return {2'b00, s, ex[7:0], q[22:0]};
  endfunction

  task automatic idle_inputs();
    inValid        = 1'b0;
    sign           = 1'b0;
    normedMantissa = '0;
    normedExp      = '0;
    mantValid      = 1'b0;
    grs            = '0;
  endtask

  task automatic gen_op();
    int r;
    sign      = 1'($urandom_range(0, 1));
    mantValid = ($urandom_range(0, 15) != 0);
    grs       = 3'($urandom_range(0, 7));
    r = $urandom_range(0, 7);
    case (r)
      0:       normedExp = 8'd0;
      1:       normedExp = 8'd254;
      2:       normedExp = 8'd255;
      default: normedExp = 8'($urandom_range(1, 254));
    endcase
    if ($urandom_range(0, 5) == 0)
      normedMantissa = {1'($urandom_range(0, 1)), 24'hFFFFFF};
    else
      normedMantissa = {1'($urandom_range(0, 1)), 1'b1,
                        23'($urandom)};
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    outReady = 1'b1;
    idle_inputs();
    #3;
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outValid got %b want 0", outValid);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 00000000", result);
    end
    checks++;
    if ({overflow, underflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b%b want 00", overflow, underflow);
    end
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inReady got %b want 1", inReady);
    end
  endtask

  typedef struct {
    logic        s;
    logic [24:0] m;
    logic [7:0]  e;
    logic        mv;
    logic [2:0]  g;
    logic [31:0] r;
    logic        o;
    logic        u;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    v[0] = '{1'b0, 25'h0800000, 8'd127, 1'b1, 3'b000, 32'h3F800000, 1'b0, 1'b0};
    v[1] = '{1'b0, 25'h0800001, 8'd127, 1'b1, 3'b100, 32'h3F800002, 1'b0, 1'b0};
    v[2] = '{1'b0, 25'h0800000, 8'd127, 1'b1, 3'b100, 32'h3F800000, 1'b0, 1'b0};
    v[3] = '{1'b0, 25'h0800000, 8'd127, 1'b1, 3'b101, 32'h3F800001, 1'b0, 1'b0};
    v[4] = '{1'b0, 25'h0FFFFFF, 8'd127, 1'b1, 3'b110, 32'h40000000, 1'b0, 1'b0};
    v[5] = '{1'b0, 25'h0FFFFFF, 8'd254, 1'b1, 3'b110, 32'h7F800000, 1'b1, 1'b0};
    v[6] = '{1'b1, 25'h0FFFFFF, 8'd254, 1'b1, 3'b110, 32'hFF800000, 1'b1, 1'b0};
    v[7] = '{1'b1, 25'h0000000, 8'd0,   1'b0, 3'b000, 32'h80000000, 1'b0, 1'b0};
    v[8] = '{1'b0, 25'h0900000, 8'd0,   1'b1, 3'b000, 32'h00000000, 1'b0, 1'b1};
    v[9] = '{1'b0, 25'h1800000, 8'd255, 1'b1, 3'b000, 32'h7F800000, 1'b1, 1'b0};
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      inValid        = 1'b1;
      sign           = v[i].s;
      normedMantissa = v[i].m;
      normedExp      = v[i].e;
      mantValid      = v[i].mv;
      grs            = v[i].g;
      @(negedge clock);
      idle_inputs();
      #1;
      checks++;
      if (outValid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early_valid got %b want 0", i, outValid);
      end
      @(negedge clock);
      checks++;
      if (outValid !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_latency outValid got %b want 1", i, outValid);
      end
      checks++;
      if ({overflow, underflow, result} !== {v[i].o, v[i].u, v[i].r}) begin
        errors++;
        $display("FAIL dir%0d_result got %h o%b u%b want %h o%b u%b",
                 i, result, overflow, underflow, v[i].r, v[i].o, v[i].u);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [33:0] q[$];
    logic [33:0] exp_v;
    logic [31:0] held;
    logic        stalled = 1'b0;
    int          outs = 0;
    for (int cyc = 0; cyc < 410; cyc++) begin
      @(negedge clock);
      if (cyc < 400) begin
        gen_op();
        inValid  = ($urandom_range(0, 3) != 0);
        outReady = ($urandom_range(0, 3) != 0);
      end else begin
        idle_inputs();
        outReady = 1'b1;
      end
      #1;
      if (stalled && outValid) begin
        checks++;
        if (result !== held) begin
          errors++;
          $display("FAIL rnd_hold got %h want %h", result, held);
        end
      end
      stalled = outValid && !outReady;
      held    = result;
      if (inValid && inReady)
        q.push_back(ref_model(sign, normedMantissa, normedExp,
                              mantValid, grs));
      if (outValid && outReady) begin
        outs++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra got %h want none", result);
        end else begin
          exp_v = q.pop_front();
          if ({overflow, underflow, result} !== exp_v) begin
            errors++;
            $display("FAIL rnd_result#%0d got %h o%b u%b want %h o%b u%b",
                     outs, result, overflow, underflow,
                     exp_v[31:0], exp_v[33], exp_v[32]);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_lost got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] m[4];
    logic [33:0] q[$];
    logic [33:0] exp_v;
    logic [31:0] held;
    logic        stalled = 1'b0;
    logic        saw_block = 1'b0;
    int          idx = 0;
    int          outs = 0;
    for (int k = 0; k < 4; k++)
      m[k] = {2'b01, 23'($urandom)};
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clock);
      outReady = !(cyc >= 3 && cyc <= 5);
      if (idx < 4) begin
        inValid        = 1'b1;
        sign           = idx[0];
        normedMantissa = m[idx];
        normedExp      = 8'(100 + idx);
        mantValid      = 1'b1;
        grs            = 3'(idx * 2 + 1);
      end else begin
        idle_inputs();
      end
      #1;
      if (!inReady) saw_block = 1'b1;
      if (stalled && outValid) begin
        checks++;
        if (result !== held) begin
          errors++;
          $display("FAIL b2b_hold got %h want %h", result, held);
        end
      end
      stalled = outValid && !outReady;
      held    = result;
      if (inValid && inReady) begin
        q.push_back(ref_model(sign, normedMantissa, normedExp,
                              mantValid, grs));
        idx++;
      end
      if (outValid && outReady) begin
        outs++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_dup got %h want none", result);
        end else begin
          exp_v = q.pop_front();
          if ({overflow, underflow, result} !== exp_v) begin
            errors++;
            $display("FAIL b2b_order#%0d got %h want %h",
                     outs, result, exp_v[31:0]);
          end
        end
      end
    end
    checks++;
    if (saw_block !== 1'b1) begin
      errors++;
      $display("FAIL b2b_inReady_drop got %b want 1", saw_block);
    end
    checks++;
    if (outs != 4 || idx != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d out %0d in want 4 4", outs, idx);
    end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    outReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      inValid        = 1'b1;
      sign           = 1'b0;
      normedMantissa = 25'h0C00000;
      normedExp      = 8'(120 + k);
      mantValid      = 1'b1;
      grs            = 3'b000;
    end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++;
    if ({outValid, inReady} !== 2'b10) begin
      errors++;
      $display("FAIL mid_full got v%b r%b want v1 r0", outValid, inReady);
    end
    #1;
    resetN = 1'b0;
    #1;
    checks++;
    if ({outValid, result} !== 33'h0) begin
      errors++;
      $display("FAIL mid_async_clear got v%b %h want v0 00000000",
               outValid, result);
    end
    @(negedge clock);
    resetN   = 1'b1;
    outReady = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("FAIL mid_inReady got %b want 1", inReady);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (outValid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL mid_stale got %0d want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Downstream neighbour of the mantissa/exponent normalizer in the single-precision FP adder datapath.
- Takes the normalized 25-bit mantissa (hidden one at bit 23), biased exponent, sign, and guard/round/sticky bits.
- Performs round-to-nearest-even, renormalizes on rounding carry, handles zero/overflow/flush-to-zero, and packs an IEEE-754 binary32 word.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- MANTISSA_N, 25, normalized mantissa width; bit 23 is the hidden one, bit 24 is the overflow position.
- EXP_N, 8, biased exponent width.
- OUT_N, 32, packed result width; must equal 1 + EXP_N + (MANTISSA_N - 2).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- inValid  input  1  upstream operand valid.
- inReady  output  1  block can accept an operand this cycle.
- sign  input  1  result sign.
- normedMantissa  input  25  normalized mantissa; bit 24 must be 0 and is ignored.
- normedExp  input  8  biased exponent after normalization.
- mantValid  input  1  normalizer found a one; 0 means the result is zero.
- grs  input  3  guard, round and sticky bits, in that order from MSB.
- outValid  output  1  result valid.
- outReady  input  1  downstream accepts the result.
- result  output  32  packed binary32 result.
- overflow  output  1  result saturated to infinity; qualified by outValid.
- underflow  output  1  result flushed to zero from a nonzero mantissa; qualified by outValid.

Behaviour:
- Reset: asynchronous, active-low (resetN = 0) clears s1Valid, s2Valid, outValid, result, overflow and underflow to 0. inReady is 1 once resetN = 1. Reset mid-operation discards all in-flight operands; nothing is replayed.
- Handshakes:
  - An input transfers when inValid & inReady.
  - An output transfers when outValid & outReady.
  - outValid = s2Valid.
  - s2 advances when !s2Valid | outReady.
  - s1 advances when !s1Valid | s2 advances.
  - inReady = s1 advances. This is combinational from outReady; it gives full throughput with no bubbles.
- Latency: exactly 2 cycles from input transfer to outValid when outReady is held at 1. Throughput is one result per cycle.
- Stage 1 (registered on input transfer):
  - Latch sign, mantValid and normedExp.
  - Compute lsb = normedMantissa[0].
  - roundUp = g & (r | s | lsb).
  - Register sum = {1'b0, normedMantissa[23:0]} + roundUp, 25 bits.
- Stage 2 (registered on s1 → s2 transfer), checked in this priority order:
  1. mantValid = 0: result = {sign, 31'b0}; overflow = 0; underflow = 0.
  2. normedExp = 0 and mantValid = 1: no subnormal support. result = {sign, 31'b0}; underflow = 1.
  3. sum[24] = 1 (rounding carry): mantissa field = sum[23:1], which is 0; expOut = normedExp + 1, computed 9 bits wide.
  4. Otherwise: mantissa field = sum[22:0]; expOut = normedExp.
  5. For cases 3 and 4, if expOut >= 255: result = {sign, 8'hFF, 23'b0}; overflow = 1.
- Stall behaviour: while outValid = 1 and outReady = 0, result, overflow and underflow hold stable. s1 holds when s2 is stalled. No data is dropped or duplicated.
- Simultaneous events: input transfer and output transfer in the same cycle are legal; stage contents shift by one.
- Flags are per-result registers, not sticky.

Decomposition:
- Shared package fp_pkg:
  - EXP_N, MANTISSA_N, EXP_MAX = 8'hFF, BIAS = 127.
  - Typedef float32_t, a packed struct {sign, exp[7:0], frac[22:0]}.
  - Typedef grs_t, packed {guard, round, sticky}.
  - Constants POS_INF and NEG_INF.
- One sub-module round_decide: combinational; inputs lsb and grs_t; output roundUp (RNE). It is reused later for other rounding modes.
- The pipeline registers and handshake logic stay in fp_round_pack.

Test Plan:
- Exact input: mant 0x0800000, exp 127, grs 000, sign 0 → result 0x3F800000 two cycles later; overflow = 0, underflow = 0.
- Ties to even:
  - mant 0x0800001, grs 100 → 0x3F800002.
  - mant 0x0800000, grs 100 → 0x3F800000.
  - mant 0x0800000, grs 101 → 0x3F800001.
- Rounding carry:
  - mant 0x0FFFFFF, exp 127, grs 110 → 0x40000000.
  - Same mantissa, exp 254 → 0x7F800000 with overflow = 1.
  - Same with sign 1 → 0xFF800000.
- Zero and flush:
  - mantValid 0, sign 1 → 0x80000000, underflow = 0.
  - mant 0x0900000, exp 0 → 0x00000000, underflow = 1.
- Back-pressure:
  - Stream 4 operands back-to-back with outReady low for cycles 3–5.
  - inReady drops when both stages are full; result holds stable.
  - All 4 results emerge in order, with none lost or duplicated.
- Reset: assert resetN = 0 with both stages full → outValid = 0 immediately (asynchronous). After release, inReady = 1 and no stale results appear.
